div_rr_scheduler: RTL

//   Shares one div_unit_pipelined_blocks instance between NREQ requesters. Round-robin arbiter plus issue/collect FSM.

---
 rtl/div_rr_scheduler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/div_rr_scheduler.sv
// div_rr_scheduler
//   Time-shares one signed divider between NREQ requesters. A round-robin
//   arbiter picks the next requester. An issue/collect FSM then runs exactly
//   one division at a time and returns the result to the requester that issued it.
//   A watchdog turns a missing div_done into a flagged, zeroed response.
//   Operands and results pass through bit-exact; no arithmetic is done here.
module div_rr_scheduler #(
  parameter int N       = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_q,
  output logic [N-1:0]      rsp_r,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              div_start,
  output logic              div_valid,
  output logic [N-1:0]      div_a,
  output logic [N-1:0]      div_b,
  input  logic [N-1:0]      div_q,
  input  logic [N-1:0]      div_r,
  input  logic              div_done,
  input  logic              div_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0]   WD_LAST  = WW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   owner_r;
  logic [N-1:0]    op_a_r;
  logic [N-1:0]    op_b_r;
  logic [N-1:0]    res_q_r;
  logic [N-1:0]    res_r_r;
  logic            res_err_r;
  logic            res_to_r;
  logic [WW-1:0]   wd_r;

  logic            grant_any_s;
  logic [IW-1:0]   grant_idx_s;
  logic [IW-1:0]   cand_s;
  logic [N-1:0]    sel_a_s;
  logic [N-1:0]    sel_b_s;
  logic            wd_expired_s;

  assign wd_expired_s = (wd_r == WD_LAST);

  // The divider sees the latched operands continuously; they only change on accept.
  assign div_a       = op_a_r;
  assign div_b       = op_b_r;
  assign rsp_q       = res_q_r;
  assign rsp_r       = res_r_r;
  assign rsp_err     = res_err_r;
  assign rsp_timeout = res_to_r;

  // Round-robin search: first valid requester starting at ptr and wrapping.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IW'((int'(ptr_r) + k) % NREQ);
      if (!grant_any_s && req_valid[cand_s]) begin
        grant_any_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx_s == IW'(k)) begin
        sel_a_s = req_a[k*N +: N];
        sel_b_s = req_b[k*N +: N];
      end else begin
        sel_a_s = sel_a_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // FSM next state and state-decoded outputs. req_ready is masked during reset
  // so every output reads 0 while rst is held.
  always_comb begin
    state_nxt_s = state_r;
    req_ready   = '0;
    rsp_valid   = '0;
    busy        = 1'b1;
    div_start   = 1'b0;
    div_valid   = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        if (grant_any_s && !rst) begin
          req_ready   = ONE_HOT0 << grant_idx_s;
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        div_start   = 1'b1;
        div_valid   = 1'b1;
        state_nxt_s = S_WAIT;
      end
      S_WAIT: begin
        if (div_done || wd_expired_s) begin
          state_nxt_s = S_RESP;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_RESP: begin
        rsp_valid   = ONE_HOT0 << owner_r;
        state_nxt_s = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: accept latch, rr pointer, watchdog and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r     <= '0;
      owner_r   <= '0;
      op_a_r    <= '0;
      op_b_r    <= '0;
      res_q_r   <= '0;
      res_r_r   <= '0;
      res_err_r <= 1'b0;
      res_to_r  <= 1'b0;
      wd_r      <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (grant_any_s) begin
            owner_r <= grant_idx_s;
            op_a_r  <= sel_a_s;
            op_b_r  <= sel_b_s;
            ptr_r   <= IW'((int'(grant_idx_s) + 1) % NREQ);
          end
        end
        S_ISSUE: begin
          wd_r <= '0;
        end
        S_WAIT: begin
          // div_done takes priority over the watchdog in the same cycle.
          if (div_done) begin
            res_q_r   <= div_q;
            res_r_r   <= div_r;
            res_err_r <= div_err;
            res_to_r  <= 1'b0;
          end else if (wd_expired_s) begin
            res_q_r   <= '0;
            res_r_r   <= '0;
            res_err_r <= 1'b0;
            res_to_r  <= 1'b1;
          end else begin
            wd_r <= wd_r + WW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
